// File: rtl/dvp_apb_pkg.sv
// rtl/dvp_apb_pkg.sv - shared state encoding, DVP register indices and response sizing
// for the DVP APB initiator.
package dvp_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [3:0] VI_CR        = 4'd0;
  localparam logic [3:0] VI_SR        = 4'd1;
  localparam logic [3:0] VP_CR        = 4'd2;
  localparam logic [3:0] VP_SR        = 4'd3;
  localparam logic [3:0] VP_START     = 4'd4;
  localparam logic [3:0] VP_END       = 4'd5;
  localparam logic [3:0] VP_SCALER    = 4'd6;
  localparam logic [3:0] VP_THRESHOLD = 4'd7;
  localparam logic [3:0] VO_CR        = 4'd8;
  localparam logic [3:0] VO_SR        = 4'd9;

  // Response entry is {error, rdata}.
  function automatic int rsp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/dvp_apb_initiator_if.sv
// rtl/dvp_apb_initiator_if.sv - command/response stream and APB bus bundle; master is
// the initiator's view, slave is the surrounding fabric and register slave.
interface dvp_apb_initiator_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] io_ahb_PADDR;
  logic              io_ahb_PSEL;
  logic              io_ahb_PENABLE;
  logic              io_ahb_PWRITE;
  logic [DATA_W-1:0] io_ahb_PWDATA;
  logic              io_ahb_PREADY;
  logic [DATA_W-1:0] io_ahb_PRDATA;
  logic              io_ahb_PSLVERROR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  io_ahb_PREADY, io_ahb_PRDATA, io_ahb_PSLVERROR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    output io_ahb_PADDR, io_ahb_PSEL, io_ahb_PENABLE, io_ahb_PWRITE, io_ahb_PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output io_ahb_PREADY, io_ahb_PRDATA, io_ahb_PSLVERROR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
    input  io_ahb_PADDR, io_ahb_PSEL, io_ahb_PENABLE, io_ahb_PWRITE, io_ahb_PWDATA
  );
endinterface

// File: rtl/dvp_apb_initiator_rsp_fifo.sv
// rtl/dvp_apb_initiator_rsp_fifo.sv - synchronous response FIFO; head entry drives the
// outputs, zero when empty.
module dvp_apb_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop frees the slot a same-cycle push needs, so full+pop+push is legal.
  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/dvp_apb_initiator.sv
// rtl/dvp_apb_initiator.sv - APB initiator: command stream to SETUP/ACCESS phases, responses
// through a buffered FIFO. Optional ACCESS timeout under macro DVP_APB_TIMEOUT_EN.
module dvp_apb_initiator
  import dvp_apb_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int RSP_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 io_ahb_PCLK,
  input  logic                 io_ahb_PRESET,
  dvp_apb_initiator_if.master  bus,
`ifdef DVP_APB_TIMEOUT_EN
  output logic                 timeout_evt,
`endif
  output logic                 busy
);
  localparam int RSP_W = rsp_width(DATA_W);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  if (RSP_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dvp_apb_initiator: RSP_DEPTH and TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_t        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_done;
  logic              w_timeout;
  logic              w_push;
  logic [RSP_W-1:0]  w_push_data;
  logic              w_rsp_valid;
  logic [RSP_W-1:0]  w_rsp_head;
  logic [CNT_W-1:0]  w_rsp_count;
  logic              w_inflight;

`ifdef DVP_APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_evt;

  assign w_timeout   = (r_state == ACCESS) & ~bus.io_ahb_PREADY &
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_evt = r_timeout_evt;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_inflight = (r_state != IDLE);
  assign w_done     = (r_state == ACCESS) & bus.io_ahb_PREADY;

  // Reserve a FIFO slot for every transfer on the bus so a push can never overflow.
  assign w_cmd_ready = ~io_ahb_PRESET & ((r_state == IDLE) | w_done) &
                       ((int'(w_rsp_count) + int'(w_inflight)) < RSP_DEPTH);
  assign w_accept    = bus.cmd_valid & w_cmd_ready;
  assign w_push      = w_done | w_timeout;

  always_comb begin
    w_push_data = {bus.io_ahb_PSLVERROR, (r_pwrite ? {DATA_W{1'b0}} : bus.io_ahb_PRDATA)};
    if (w_timeout) w_push_data = {1'b1, {DATA_W{1'b0}}};
  end

  always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
    if (io_ahb_PRESET) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
`ifdef DVP_APB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_evt <= 1'b0;
`endif
    end else begin
`ifdef DVP_APB_TIMEOUT_EN
      r_timeout_evt <= 1'b0;
`endif
      if (w_accept) begin
        r_paddr  <= bus.cmd_addr;
        r_pwrite <= bus.cmd_write;
        r_pwdata <= bus.cmd_wdata;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= SETUP;
            r_psel  <= 1'b1;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
`ifdef DVP_APB_TIMEOUT_EN
          r_to_cnt  <= '0;
`endif
        end
        ACCESS: begin
          if (bus.io_ahb_PREADY) begin
            r_penable <= 1'b0;
            if (w_accept) begin
              r_state <= SETUP;
            end else begin
              r_state <= IDLE;
              r_psel  <= 1'b0;
            end
`ifdef DVP_APB_TIMEOUT_EN
          end else if (w_timeout) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_timeout_evt <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
          end
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  dvp_apb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk         (io_ahb_PCLK),
    .rst         (io_ahb_PRESET),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (bus.rsp_ready),
    .o_valid     (w_rsp_valid),
    .o_data      (w_rsp_head),
    .o_count     (w_rsp_count)
  );

  assign bus.cmd_ready      = w_cmd_ready;
  assign bus.rsp_valid      = w_rsp_valid;
  assign bus.rsp_rdata      = w_rsp_head[DATA_W-1:0];
  assign bus.rsp_error      = w_rsp_head[DATA_W];
  assign bus.io_ahb_PADDR   = r_paddr;
  assign bus.io_ahb_PSEL    = r_psel;
  assign bus.io_ahb_PENABLE = r_penable;
  assign bus.io_ahb_PWRITE  = r_pwrite;
  assign bus.io_ahb_PWDATA  = r_pwdata;
  assign busy               = w_inflight;

endmodule

// File: tb/tb_dvp_apb_initiator.sv
// tb/tb_dvp_apb_initiator.sv - directed vector bench for dvp_apb_initiator against a
// DVP register slave model with programmable PREADY stall and PSLVERROR.
module tb_dvp_apb_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  dvp_apb_initiator_if #(.ADDR_W(4), .DATA_W(32)) bus ();

`ifdef DVP_APB_TIMEOUT_EN
  logic timeout_evt;
`endif

  dvp_apb_initiator #(
    .ADDR_W(4), .DATA_W(32), .RSP_DEPTH(2), .TIMEOUT_CYCLES(255)
  ) dut (
    .io_ahb_PCLK   (clk),
    .io_ahb_PRESET (rst),
    .bus           (bus),
`ifdef DVP_APB_TIMEOUT_EN
    .timeout_evt   (timeout_evt),
`endif
    .busy          (busy)
  );

  logic [31:0] regs [16];
  int          stall_n  = 0;
  int          wait_cnt = 0;
  logic        err_en   = 1'b0;
  int          pen_cnt  = 0;
  int          xfer_cnt = 0;
  int          evt_cnt  = 0;
  int          cyc      = 0;
  logic [31:0] got_d [$];

  assign bus.io_ahb_PREADY    = (wait_cnt == 0);
  assign bus.io_ahb_PRDATA    = (bus.io_ahb_PADDR < 4'd10) ? regs[bus.io_ahb_PADDR] : 32'h0;
  assign bus.io_ahb_PSLVERROR = err_en;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.io_ahb_PSEL && !bus.io_ahb_PENABLE) wait_cnt <= stall_n;
    else if (bus.io_ahb_PSEL && bus.io_ahb_PENABLE && wait_cnt > 0) wait_cnt <= wait_cnt - 1;
    if (bus.io_ahb_PSEL && bus.io_ahb_PENABLE) pen_cnt <= pen_cnt + 1;
    if (bus.io_ahb_PSEL && bus.io_ahb_PENABLE && bus.io_ahb_PREADY) begin
      xfer_cnt <= xfer_cnt + 1;
      if (bus.io_ahb_PWRITE) regs[bus.io_ahb_PADDR] <= bus.io_ahb_PWDATA;
    end
    if (bus.rsp_valid && bus.rsp_ready) got_d.push_back(bus.rsp_rdata);
`ifdef DVP_APB_TIMEOUT_EN
    if (timeout_evt) evt_cnt <= evt_cnt + 1;
`endif
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Returns at the falling edge right after the accepting edge, cmd_valid still high.
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 100), 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          stall;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic do_txn(input vec_t v, input int idx);
    int   p0, x0, k;
    logic stable;
    stall_n = v.stall;
    err_en  = v.err;
    p0 = pen_cnt;
    x0 = xfer_cnt;
    issue(v.wr, v.addr, v.wdata);
    bus.cmd_valid = 1'b0;
    chk($sformatf("v%0d_setup_phase", idx), {30'd0, bus.io_ahb_PSEL, bus.io_ahb_PENABLE}, 32'd2);
    k = 1;
    stable = 1'b1;
    while (!bus.rsp_valid && k < 60) begin
      if (!(bus.io_ahb_PSEL && bus.io_ahb_PADDR == v.addr && bus.io_ahb_PWDATA == v.wdata &&
            bus.io_ahb_PWRITE == v.wr)) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(k), 32'(3 + v.stall));
    chk($sformatf("v%0d_addr_stable", idx), 32'(stable), 32'd1);
    chk($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_error", idx), 32'(bus.rsp_error), 32'(v.exp_err));
    chk($sformatf("v%0d_penable_cycles", idx), 32'(pen_cnt - p0), 32'(1 + v.stall));
    chk($sformatf("v%0d_transfers", idx), 32'(xfer_cnt - x0), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    err_en = 1'b0;
    chk($sformatf("v%0d_drained", idx), {30'd0, bus.rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    int t0, t1, x0, n, ev0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[0] = 32'h0000_0005;
    regs[8] = 32'h0000_0003;

    vecs[0] = '{1'b0, 4'd0, 32'h0,         0, 1'b0, 32'h0000_0005, 1'b0};
    vecs[1] = '{1'b1, 4'd4, 32'h0010_0020, 0, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 4'd4, 32'h0,         0, 1'b0, 32'h0010_0020, 1'b0};
    vecs[3] = '{1'b0, 4'd8, 32'h0,         5, 1'b0, 32'h0000_0003, 1'b0};
    vecs[4] = '{1'b0, 4'd0, 32'h0,         0, 1'b1, 32'h0000_0005, 1'b1};
    vecs[5] = '{1'b0, 4'd0, 32'h0,         0, 1'b0, 32'h0000_0005, 1'b0};
    vecs[6] = '{1'b1, 4'd4, 32'hCAFE_0001, 2, 1'b0, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 4'd4, 32'h0,         0, 1'b0, 32'hCAFE_0001, 1'b0};
    vecs[8] = '{1'b0, 4'd15, 32'h0,        0, 1'b0, 32'h0,         1'b0};

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 4'd0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel_penable", {30'd0, bus.io_ahb_PSEL, bus.io_ahb_PENABLE}, 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", {bus.rsp_error, bus.rsp_rdata[30:0]}, 32'd0);
    chk("rst_paddr_pwdata", {28'd0, bus.io_ahb_PADDR} | bus.io_ahb_PWDATA, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_txn(vecs[i], i);

    // Back-to-back writes with responses drained: one accept every 2 cycles.
    bus.rsp_ready = 1'b1;
    issue(1'b1, 4'd9, 32'h11);
    t0 = cyc;
    issue(1'b1, 4'd9, 32'h22);
    t1 = cyc;
    bus.cmd_valid = 1'b0;
    chk("b2b_accept_spacing", 32'(t1 - t0), 32'd2);
    repeat (5) @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("b2b_drained", 32'(bus.rsp_valid), 32'd0);

    // Response backpressure: only RSP_DEPTH transfers may complete.
    got_d.delete();
    x0 = xfer_cnt;
    issue(1'b0, 4'd0, 32'h0);
    issue(1'b0, 4'd0, 32'h0);
    bus.cmd_addr = 4'd8;
    repeat (8) @(negedge clk);
    chk("bp_transfers", 32'(xfer_cnt - x0), 32'd2);
    chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    issue(1'b0, 4'd8, 32'h0);
    issue(1'b0, 4'd10, 32'h0);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (got_d.size() < 4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    bus.rsp_ready = 1'b0;
    chk("bp_rsp_count", 32'(got_d.size()), 32'd4);
    if (got_d.size() == 4) begin
      chk("bp_order0", got_d[0], 32'h5);
      chk("bp_order1", got_d[1], 32'h5);
      chk("bp_order2", got_d[2], 32'h3);
      chk("bp_order3", got_d[3], 32'h0);
    end

    // Reset during a stalled ACCESS aborts with no response.
    stall_n = 20;
    issue(1'b0, 4'd0, 32'h0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_access", 32'(bus.io_ahb_PENABLE), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_psel_penable", {30'd0, bus.io_ahb_PSEL, bus.io_ahb_PENABLE}, 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stall_n = 0;
    repeat (30) @(negedge clk);
    chk("mid_no_response", 32'(bus.rsp_valid), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);

`ifdef DVP_APB_TIMEOUT_EN
    stall_n = 100000;
    ev0 = evt_cnt;
    issue(1'b0, 4'd0, 32'h0);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rdata", bus.rsp_rdata, 32'h0);
    chk("to_error", 32'(bus.rsp_error), 32'd1);
    chk("to_psel_low", 32'(bus.io_ahb_PSEL), 32'd0);
    chk("to_evt_pulses", 32'(evt_cnt - ev0), 32'd1);
`else
    ev0 = evt_cnt;
    chk("no_timeout_evts", 32'(ev0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
